// File: rtl/iobuf_bus_responder.sv
// Responder end of a half-duplex IOBUF pad bus: samples a command, then drives response beats.
// Optional DRIVE-state response timeout (ERR pulse) is enabled by defining IOBUF_RSP_TIMEOUT_EN.
module iobuf_bus_responder #(
  parameter int WIDTH   = 8,
  parameter int TA      = 2,
  parameter int TIMEOUT = 255
) (
  input  logic             C,
  input  logic             R,
  input  logic [WIDTH-1:0] PAD_O,
  output logic [WIDTH-1:0] PAD_I,
  output logic             PAD_T,
  input  logic             STB,
  output logic             ACK,
  output logic [WIDTH-1:0] CMD_DATA,
  output logic             CMD_VALID,
  input  logic [WIDTH-1:0] RSP_DATA,
  input  logic             RSP_VALID,
  input  logic             RSP_LAST,
  output logic             RSP_READY,
  output logic             BUSY,
  output logic             ERR
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_TURN_IN  = 2'd1,
    S_DRIVE    = 2'd2,
    S_TURN_OUT = 2'd3
  } state_t;

  localparam logic [3:0] TA_CNT = TA[3:0];

  if ((WIDTH < 1) || (WIDTH > 32) || (TA < 1) || (TA > 15) ||
      (TIMEOUT < 1) || (TIMEOUT > 65535)) begin : g_param_out_of_range
  end

  state_t           r_state;
  logic [3:0]       r_cnt;
  logic             r_last;
  logic [WIDTH-1:0] r_pad_i;
  logic             r_pad_t;
  logic             r_ack;
  logic [WIDTH-1:0] r_cmd_data;
  logic             r_cmd_valid;
  logic             r_rsp_ready;
  logic             r_busy;
  logic             r_err;

  state_t           w_state_nxt;
  logic [3:0]       w_cnt_nxt;
  logic             w_last_nxt;
  logic [WIDTH-1:0] w_pad_i_nxt;
  logic             w_pad_t_nxt;
  logic             w_ack_nxt;
  logic [WIDTH-1:0] w_cmd_data_nxt;
  logic             w_cmd_valid_nxt;
  logic             w_rsp_ready_nxt;
  logic             w_busy_nxt;
  logic             w_err_nxt;
  logic             w_hs;

`ifdef IOBUF_RSP_TIMEOUT_EN
  localparam logic [15:0] TMO_LIM = TIMEOUT[15:0];
  logic [15:0] r_tmo;
  logic [15:0] w_tmo_nxt;
  logic [15:0] w_tmo_inc;
  assign w_tmo_inc = r_tmo + 16'd1;
`endif

  // r_rsp_ready is only ever high in DRIVE before the final beat
  assign w_hs = RSP_VALID & r_rsp_ready;

  // Next-state and next-output decode
  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_last_nxt      = r_last;
    w_pad_i_nxt     = r_pad_i;
    w_pad_t_nxt     = r_pad_t;
    w_ack_nxt       = 1'b0;
    w_cmd_data_nxt  = r_cmd_data;
    w_cmd_valid_nxt = 1'b0;
    w_rsp_ready_nxt = r_rsp_ready;
    w_busy_nxt      = r_busy;
    w_err_nxt       = 1'b0;
`ifdef IOBUF_RSP_TIMEOUT_EN
    w_tmo_nxt       = r_tmo;
`endif
    case (r_state)
      S_IDLE: begin
        w_pad_t_nxt = 1'b1;
        if (STB) begin
          w_cmd_data_nxt  = PAD_O;
          w_cmd_valid_nxt = 1'b1;
          w_busy_nxt      = 1'b1;
          w_cnt_nxt       = TA_CNT;
          w_state_nxt     = S_TURN_IN;
        end else begin
          w_busy_nxt = 1'b0;
        end
      end
      S_TURN_IN: begin
        if (r_cnt <= 4'd1) begin
          w_state_nxt     = S_DRIVE;
          w_rsp_ready_nxt = 1'b1;
          w_last_nxt      = 1'b0;
`ifdef IOBUF_RSP_TIMEOUT_EN
          w_tmo_nxt       = 16'd0;
`endif
        end else begin
          w_cnt_nxt = r_cnt - 4'd1;
        end
      end
      S_DRIVE: begin
        // r_last marks the ACK cycle of the final beat; release the pad after it
        if (r_last) begin
          w_state_nxt = S_TURN_OUT;
          w_pad_t_nxt = 1'b1;
          w_cnt_nxt   = TA_CNT;
          w_last_nxt  = 1'b0;
        end else if (w_hs) begin
          w_pad_i_nxt = RSP_DATA;
          w_pad_t_nxt = 1'b0;
          w_ack_nxt   = 1'b1;
`ifdef IOBUF_RSP_TIMEOUT_EN
          w_tmo_nxt   = 16'd0;
`endif
          if (RSP_LAST) begin
            w_rsp_ready_nxt = 1'b0;
            w_last_nxt      = 1'b1;
          end else begin
            w_rsp_ready_nxt = 1'b1;
          end
        end else begin
`ifdef IOBUF_RSP_TIMEOUT_EN
          // Expiry is judged at the edge ending the TIMEOUT-th unanswered cycle
          if (w_tmo_inc >= TMO_LIM) begin
            w_pad_i_nxt     = {WIDTH{1'b1}};
            w_pad_t_nxt     = 1'b0;
            w_ack_nxt       = 1'b1;
            w_err_nxt       = 1'b1;
            w_rsp_ready_nxt = 1'b0;
            w_last_nxt      = 1'b1;
          end else begin
            w_tmo_nxt = w_tmo_inc;
          end
`else
          w_rsp_ready_nxt = 1'b1;
`endif
        end
      end
      S_TURN_OUT: begin
        w_pad_t_nxt = 1'b1;
        if (r_cnt <= 4'd1) begin
          w_state_nxt = S_IDLE;
          w_busy_nxt  = 1'b0;
        end else begin
          w_cnt_nxt = r_cnt - 4'd1;
        end
      end
      default: begin
        w_state_nxt     = S_IDLE;
        w_pad_t_nxt     = 1'b1;
        w_rsp_ready_nxt = 1'b0;
        w_busy_nxt      = 1'b0;
        w_last_nxt      = 1'b0;
      end
    endcase
  end

  // State and registered outputs
  always_ff @(posedge C) begin
    if (R) begin
      r_state     <= S_IDLE;
      r_cnt       <= 4'd0;
      r_last      <= 1'b0;
      r_pad_i     <= {WIDTH{1'b0}};
      r_pad_t     <= 1'b1;
      r_ack       <= 1'b0;
      r_cmd_data  <= {WIDTH{1'b0}};
      r_cmd_valid <= 1'b0;
      r_rsp_ready <= 1'b0;
      r_busy      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_last      <= w_last_nxt;
      r_pad_i     <= w_pad_i_nxt;
      r_pad_t     <= w_pad_t_nxt;
      r_ack       <= w_ack_nxt;
      r_cmd_data  <= w_cmd_data_nxt;
      r_cmd_valid <= w_cmd_valid_nxt;
      r_rsp_ready <= w_rsp_ready_nxt;
      r_busy      <= w_busy_nxt;
      r_err       <= w_err_nxt;
    end
  end

`ifdef IOBUF_RSP_TIMEOUT_EN
  // Unanswered-cycle counter for the DRIVE timeout
  always_ff @(posedge C) begin
    if (R) begin
      r_tmo <= 16'd0;
    end else begin
      r_tmo <= w_tmo_nxt;
    end
  end
`endif

  assign PAD_I     = r_pad_i;
  assign PAD_T     = r_pad_t;
  assign ACK       = r_ack;
  assign CMD_DATA  = r_cmd_data;
  assign CMD_VALID = r_cmd_valid;
  assign RSP_READY = r_rsp_ready;
  assign BUSY      = r_busy;
  assign ERR       = r_err;

endmodule

// File: tb/tb_iobuf_bus_responder.sv
// Scoreboard bench for iobuf_bus_responder (WIDTH=8, TA=2, TIMEOUT=5).
module tb_iobuf_bus_responder;
  logic       C;
  logic       R;
  logic [7:0] PAD_O;
  logic [7:0] PAD_I;
  logic       PAD_T;
  logic       STB;
  logic       ACK;
  logic [7:0] CMD_DATA;
  logic       CMD_VALID;
  logic [7:0] RSP_DATA;
  logic       RSP_VALID;
  logic       RSP_LAST;
  logic       RSP_READY;
  logic       BUSY;
  logic       ERR;

  int n_checks = 0;
  int n_errors = 0;
  logic [7:0] q_beat[$];
  logic [7:0] q_cmd[$];

  iobuf_bus_responder #(.WIDTH(8), .TA(2), .TIMEOUT(5)) dut (
    .C(C), .R(R), .PAD_O(PAD_O), .PAD_I(PAD_I), .PAD_T(PAD_T), .STB(STB),
    .ACK(ACK), .CMD_DATA(CMD_DATA), .CMD_VALID(CMD_VALID),
    .RSP_DATA(RSP_DATA), .RSP_VALID(RSP_VALID), .RSP_LAST(RSP_LAST),
    .RSP_READY(RSP_READY), .BUSY(BUSY), .ERR(ERR)
  );

  initial C = 1'b0;
  always #5 C = ~C;

  // Scoreboard: every ACK beat and every CMD_VALID pulse must match a queued expectation
  always @(negedge C) begin
    if (ACK === 1'b1) begin
      n_checks++;
      if (q_beat.size() == 0) begin
        n_errors++;
        $display("FAIL beat_unexpected: PAD_I=%h with no beat expected", PAD_I);
      end else begin
        logic [7:0] exp_b;
        exp_b = q_beat.pop_front();
        if (PAD_I !== exp_b || PAD_T !== 1'b0) begin
          n_errors++;
          $display("FAIL beat_data: PAD_I=%h PAD_T=%b expected PAD_I=%h PAD_T=0", PAD_I, PAD_T, exp_b);
        end
      end
    end
    if (CMD_VALID === 1'b1) begin
      n_checks++;
      if (q_cmd.size() == 0) begin
        n_errors++;
        $display("FAIL cmd_unexpected: CMD_DATA=%h with no command expected", CMD_DATA);
      end else begin
        logic [7:0] exp_c;
        exp_c = q_cmd.pop_front();
        if (CMD_DATA !== exp_c) begin
          n_errors++;
          $display("FAIL cmd_data: CMD_DATA=%h expected %h", CMD_DATA, exp_c);
        end
      end
    end
  end

  task automatic tick();
    @(posedge C);
    #1;
  endtask

  task automatic start_cmd(input logic [7:0] d);
    STB = 1'b1;
    PAD_O = d;
    q_cmd.push_back(d);
    tick();
    STB = 1'b0;
    PAD_O = 8'h00;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (RSP_READY !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    n_checks++;
    if (RSP_READY !== 1'b1) begin
      n_errors++;
      $display("FAIL wait_ready: RSP_READY=%b after %0d cycles, expected 1", RSP_READY, n);
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while (BUSY !== 1'b0 && n < 30) begin
      tick();
      n++;
    end
    n_checks++;
    if (BUSY !== 1'b0) begin
      n_errors++;
      $display("FAIL wait_idle: BUSY=%b after %0d cycles, expected 0", BUSY, n);
    end
  endtask

  task automatic send_last(input logic [7:0] d);
    RSP_DATA = d;
    RSP_VALID = 1'b1;
    RSP_LAST = 1'b1;
    q_beat.push_back(d);
    tick();
    RSP_VALID = 1'b0;
    RSP_LAST = 1'b0;
  endtask

  task automatic test_reset();
    R = 1'b1;
    repeat (3) tick();
    n_checks++;
    if (PAD_T !== 1'b1 || PAD_I !== 8'h00 || ACK !== 1'b0 || CMD_DATA !== 8'h00 ||
        CMD_VALID !== 1'b0 || RSP_READY !== 1'b0 || BUSY !== 1'b0 || ERR !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_values: T=%b I=%h A=%b CD=%h CV=%b RR=%b B=%b E=%b expected 1 00 0 00 0 0 0 0",
               PAD_T, PAD_I, ACK, CMD_DATA, CMD_VALID, RSP_READY, BUSY, ERR);
    end
    R = 1'b0;
    tick();
  endtask

  task automatic test_single_beat();
    start_cmd(8'hA5);
    n_checks++;
    if (CMD_VALID !== 1'b1 || CMD_DATA !== 8'hA5 || BUSY !== 1'b1 || RSP_READY !== 1'b0) begin
      n_errors++;
      $display("FAIL single_cycle1: CV=%b CD=%h B=%b RR=%b expected 1 a5 1 0", CMD_VALID, CMD_DATA, BUSY, RSP_READY);
    end
    tick();
    n_checks++;
    if (CMD_VALID !== 1'b0 || RSP_READY !== 1'b0 || PAD_T !== 1'b1) begin
      n_errors++;
      $display("FAIL single_cycle2: CV=%b RR=%b T=%b expected 0 0 1", CMD_VALID, RSP_READY, PAD_T);
    end
    tick();
    n_checks++;
    if (RSP_READY !== 1'b1 || PAD_T !== 1'b1) begin
      n_errors++;
      $display("FAIL single_cycle3: RR=%b T=%b expected 1 1", RSP_READY, PAD_T);
    end
    send_last(8'h3C);
    n_checks++;
    if (ACK !== 1'b1 || PAD_I !== 8'h3C || PAD_T !== 1'b0 || RSP_READY !== 1'b0) begin
      n_errors++;
      $display("FAIL single_cycle4: A=%b I=%h T=%b RR=%b expected 1 3c 0 0", ACK, PAD_I, PAD_T, RSP_READY);
    end
    for (int c = 5; c <= 6; c++) begin
      tick();
      n_checks++;
      if (PAD_T !== 1'b1 || ACK !== 1'b0 || BUSY !== 1'b1) begin
        n_errors++;
        $display("FAIL single_turn_out: cycle %0d T=%b A=%b B=%b expected 1 0 1", c, PAD_T, ACK, BUSY);
      end
    end
    tick();
    n_checks++;
    if (BUSY !== 1'b0 || PAD_T !== 1'b1) begin
      n_errors++;
      $display("FAIL single_cycle7: B=%b T=%b expected 0 1", BUSY, PAD_T);
    end
  endtask

  task automatic test_burst();
    start_cmd(8'h10);
    wait_ready();
    for (int i = 1; i <= 4; i++) begin
      RSP_DATA = 8'(i);
      RSP_VALID = 1'b1;
      RSP_LAST = (i == 4);
      q_beat.push_back(8'(i));
      tick();
      n_checks++;
      if (ACK !== 1'b1 || PAD_T !== 1'b0 || PAD_I !== 8'(i)) begin
        n_errors++;
        $display("FAIL burst_beat%0d: A=%b T=%b I=%h expected 1 0 %h", i, ACK, PAD_T, PAD_I, 8'(i));
      end
    end
    RSP_VALID = 1'b0;
    RSP_LAST = 1'b0;
    tick();
    n_checks++;
    if (PAD_T !== 1'b1 || ACK !== 1'b0) begin
      n_errors++;
      $display("FAIL burst_release: T=%b A=%b expected 1 0", PAD_T, ACK);
    end
    wait_idle();
  endtask

  task automatic test_gapped_burst();
    start_cmd(8'h20);
    wait_ready();
    RSP_DATA = 8'h11;
    RSP_VALID = 1'b1;
    q_beat.push_back(8'h11);
    tick();
    RSP_VALID = 1'b0;
    for (int g = 0; g < 3; g++) begin
      tick();
      n_checks++;
      if (PAD_T !== 1'b0 || PAD_I !== 8'h11 || ACK !== 1'b0 || RSP_READY !== 1'b1) begin
        n_errors++;
        $display("FAIL gap_hold%0d: T=%b I=%h A=%b RR=%b expected 0 11 0 1", g, PAD_T, PAD_I, ACK, RSP_READY);
      end
    end
    send_last(8'h22);
    tick();
    n_checks++;
    if (PAD_T !== 1'b1) begin
      n_errors++;
      $display("FAIL gap_release: T=%b expected 1", PAD_T);
    end
    wait_idle();
  endtask

  task automatic test_strobe_filter();
    start_cmd(8'h30);
    PAD_O = 8'hEE;
    STB = 1'b1;
    tick();
    STB = 1'b0;
    n_checks++;
    if (CMD_VALID !== 1'b0 || CMD_DATA !== 8'h30) begin
      n_errors++;
      $display("FAIL stb_turn_in: CV=%b CD=%h expected 0 30", CMD_VALID, CMD_DATA);
    end
    wait_ready();
    STB = 1'b1;
    tick();
    STB = 1'b0;
    send_last(8'h44);
    tick();
    STB = 1'b1;
    PAD_O = 8'h5A;
    q_cmd.push_back(8'h5A);
    tick();
    n_checks++;
    if (CMD_VALID !== 1'b0 || BUSY !== 1'b1) begin
      n_errors++;
      $display("FAIL stb_turn_out: CV=%b B=%b expected 0 1", CMD_VALID, BUSY);
    end
    tick();
    n_checks++;
    if (CMD_VALID !== 1'b0 || BUSY !== 1'b0) begin
      n_errors++;
      $display("FAIL stb_first_idle: CV=%b B=%b expected 0 0", CMD_VALID, BUSY);
    end
    tick();
    STB = 1'b0;
    n_checks++;
    if (CMD_VALID !== 1'b1 || CMD_DATA !== 8'h5A || BUSY !== 1'b1) begin
      n_errors++;
      $display("FAIL stb_held_restart: CV=%b CD=%h B=%b expected 1 5a 1", CMD_VALID, CMD_DATA, BUSY);
    end
    wait_ready();
    send_last(8'h55);
    wait_idle();
  endtask

  task automatic test_reset_mid_drive();
    start_cmd(8'h40);
    wait_ready();
    RSP_DATA = 8'h77;
    RSP_VALID = 1'b1;
    q_beat.push_back(8'h77);
    tick();
    RSP_VALID = 1'b0;
    n_checks++;
    if (PAD_T !== 1'b0) begin
      n_errors++;
      $display("FAIL mid_drive_setup: T=%b expected 0", PAD_T);
    end
    R = 1'b1;
    tick();
    n_checks++;
    if (PAD_T !== 1'b1 || ACK !== 1'b0 || BUSY !== 1'b0 || RSP_READY !== 1'b0 || PAD_I !== 8'h00) begin
      n_errors++;
      $display("FAIL mid_reset: T=%b A=%b B=%b RR=%b I=%h expected 1 0 0 0 00", PAD_T, ACK, BUSY, RSP_READY, PAD_I);
    end
    repeat (2) tick();
    R = 1'b0;
    tick();
    start_cmd(8'hC3);
    n_checks++;
    if (CMD_VALID !== 1'b1 || BUSY !== 1'b1) begin
      n_errors++;
      $display("FAIL post_reset_idle: CV=%b B=%b expected 1 1", CMD_VALID, BUSY);
    end
    wait_ready();
    send_last(8'h88);
    wait_idle();
  endtask

  task automatic test_timeout();
`ifdef IOBUF_RSP_TIMEOUT_EN
    start_cmd(8'h50);
    wait_ready();
    for (int c = 0; c < 4; c++) begin
      tick();
      n_checks++;
      if (ACK !== 1'b0 || ERR !== 1'b0 || RSP_READY !== 1'b1) begin
        n_errors++;
        $display("FAIL tmo_wait%0d: A=%b E=%b RR=%b expected 0 0 1", c, ACK, ERR, RSP_READY);
      end
    end
    q_beat.push_back(8'hFF);
    tick();
    n_checks++;
    if (ACK !== 1'b1 || ERR !== 1'b1 || PAD_I !== 8'hFF || PAD_T !== 1'b0 || RSP_READY !== 1'b0) begin
      n_errors++;
      $display("FAIL tmo_beat: A=%b E=%b I=%h T=%b RR=%b expected 1 1 ff 0 0", ACK, ERR, PAD_I, PAD_T, RSP_READY);
    end
    for (int c = 0; c < 2; c++) begin
      tick();
      n_checks++;
      if (PAD_T !== 1'b1 || ERR !== 1'b0 || ACK !== 1'b0 || BUSY !== 1'b1) begin
        n_errors++;
        $display("FAIL tmo_release%0d: T=%b E=%b A=%b B=%b expected 1 0 0 1", c, PAD_T, ERR, ACK, BUSY);
      end
    end
    tick();
    n_checks++;
    if (BUSY !== 1'b0) begin
      n_errors++;
      $display("FAIL tmo_idle: B=%b expected 0", BUSY);
    end
`else
    int bad = 0;
    start_cmd(8'h50);
    wait_ready();
    for (int c = 0; c < 100; c++) begin
      tick();
      if (ERR !== 1'b0 || BUSY !== 1'b1 || ACK !== 1'b0) bad++;
    end
    n_checks++;
    if (bad != 0) begin
      n_errors++;
      $display("FAIL no_timeout: %0d of 100 cycles had ERR!=0, BUSY!=1 or ACK!=0, expected 0", bad);
    end
    send_last(8'h99);
    wait_idle();
`endif
  endtask

  initial begin
    R = 1'b1;
    STB = 1'b0;
    PAD_O = 8'h00;
    RSP_DATA = 8'h00;
    RSP_VALID = 1'b0;
    RSP_LAST = 1'b0;
    test_reset();
    test_single_beat();
    test_burst();
    test_gapped_burst();
    test_strobe_filter();
    test_reset_mid_drive();
    test_timeout();
    repeat (3) tick();
    n_checks++;
    if (q_beat.size() != 0 || q_cmd.size() != 0) begin
      n_errors++;
      $display("FAIL scoreboard_drain: %0d beats and %0d commands outstanding, expected 0 and 0",
               q_beat.size(), q_cmd.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
